// File: rtl/sram_like_responder.sv
// Responder end of the sram-like req/addr_ok/data_ok handshake in front of a
// 1-cycle synchronous RAM, with programmable response delay and back-pressure.
module sram_like_responder #(
  parameter int OUTSTANDING = 2,
  parameter int DELAY       = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        req_stall,
  input  logic        resp_stall,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam logic [PW-1:0] LAST     = PW'(OUTSTANDING - 1);
  localparam logic [CW-1:0] FULL     = CW'(OUTSTANDING);
  localparam logic [3:0]    CNT_INIT = 4'(DELAY);

  logic          run;
  logic [CW-1:0] inflight;
  logic [PW-1:0] wptr, rptr, cap_idx;
  logic          cap_pending;
  logic          accept;

  logic          q_wr   [OUTSTANDING];
  logic [3:0]    q_cnt  [OUTSTANDING];
  logic          q_dv   [OUTSTANDING];
  logic [31:0]   q_data [OUTSTANDING];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // run holds every output at zero while reset is asserted and for the edge it is released on
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) run <= 1'b0;
    else         run <= 1'b1;
  end

  always_comb begin
    addr_ok   = run && !req_stall && (inflight < FULL);
    accept    = req && addr_ok;
    data_ok   = run && !resp_stall && (inflight != '0) && (q_cnt[rptr] == 4'd0);
    ram_en    = accept;
    ram_addr  = run ? {addr[31:2], 2'b00} : 32'd0;
    ram_wdata = run ? wdata : 32'd0;
    ram_wen   = 4'b0000;
    if (accept && wr) begin
      case (size)
        2'd0:    ram_wen = 4'b0001 << addr[1:0];
        2'd1:    ram_wen = 4'b0011 << addr[1:0];
        default: ram_wen = 4'b1111;
      endcase
    end
    rdata = 32'd0;
    if (data_ok && !q_wr[rptr]) begin
      // head pushed last cycle has not captured yet: take the RAM output directly
      rdata = q_dv[rptr] ? q_data[rptr] : ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight    <= '0;
      wptr        <= '0;
      rptr        <= '0;
      cap_idx     <= '0;
      cap_pending <= 1'b0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        q_wr[i]   <= 1'b0;
        q_cnt[i]  <= 4'd0;
        q_dv[i]   <= 1'b0;
        q_data[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (q_cnt[i] != 4'd0) q_cnt[i] <= q_cnt[i] - 4'd1;
      end
      cap_pending <= accept;
      cap_idx     <= wptr;
      if (cap_pending) begin
        q_dv[cap_idx]   <= 1'b1;
        q_data[cap_idx] <= q_wr[cap_idx] ? 32'd0 : ram_rdata;
      end
      if (accept) begin
        q_wr[wptr]   <= wr;
        q_cnt[wptr]  <= CNT_INIT;
        q_dv[wptr]   <= 1'b0;
        q_data[wptr] <= 32'd0;
        wptr         <= ptr_inc(wptr);
      end
      if (data_ok) rptr <= ptr_inc(rptr);
      case ({accept, data_ok})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: two instances (DELAY 0 and 3) on shared stimulus,
// each with a RAM stub, checked every cycle against a transaction-level model.
module tb_sram_like_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, req, wr, req_stall, resp_stall;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [1:0]  aok, dok, ren;
  logic [3:0]  wen   [2];
  logic [31:0] rdat  [2];
  logic [31:0] raddr [2];
  logic [31:0] rwdat [2];
  logic [31:0] rrd   [2];

  sram_like_responder #(.OUTSTANDING(2), .DELAY(0)) u_d0 (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rdat[0]),
    .req_stall(req_stall), .resp_stall(resp_stall), .ram_en(ren[0]),
    .ram_wen(wen[0]), .ram_addr(raddr[0]), .ram_wdata(rwdat[0]), .ram_rdata(rrd[0]));

  sram_like_responder #(.OUTSTANDING(2), .DELAY(3)) u_d3 (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rdat[1]),
    .req_stall(req_stall), .resp_stall(resp_stall), .ram_en(ren[1]),
    .ram_wen(wen[1]), .ram_addr(raddr[1]), .ram_wdata(rwdat[1]), .ram_rdata(rrd[1]));

  // RAM stubs: synchronous read, byte-lane writes
  logic [31:0] ram_st [2][4096];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ren[k]) begin
        rrd[k] <= ram_st[k][raddr[k][13:2]];
        for (int b = 0; b < 4; b++)
          if (wen[k][b]) ram_st[k][raddr[k][13:2]][8*b +: 8] = rwdat[k][8*b +: 8];
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
    int nbytes;
    logic [3:0] m;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    m = 4'b0000;
    for (int b = 0; b < 4; b++)
      m[b] = (nbytes == 4) ? 1'b1 : ((b >= int'(a)) && (b < int'(a) + nbytes));
    return m;
  endfunction

  // Reference model: per instance, a queue of {due cycle, data} and a shadow memory
  int          mdue  [2][8];
  logic [31:0] mdat  [2][8];
  int          mhead [2];
  int          mcnt  [2];
  logic [31:0] mmem  [2][4096];
  int          cyc = 0;
  logic        tb_run = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) tb_run <= 1'b0;
    else         tb_run <= 1'b1;
  end

  always @(negedge clk) begin
    logic ea, ed, eacc;
    logic [31:0] er;
    logic [3:0] ew;
    int idx, slot;
    string p;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? "d0" : "d3";
      if (!resetn) begin
        chk({p, " rst addr_ok"}, aok[k], 0);
        chk({p, " rst data_ok"}, dok[k], 0);
        chk({p, " rst rdata"}, rdat[k], 0);
        chk({p, " rst ram_en"}, ren[k], 0);
        chk({p, " rst ram_wen"}, wen[k], 0);
        chk({p, " rst ram_addr"}, raddr[k], 0);
        chk({p, " rst ram_wdata"}, rwdat[k], 0);
        mcnt[k] = 0;
        mhead[k] = 0;
      end else begin
        ea   = tb_run && !req_stall && (mcnt[k] < 2);
        eacc = ea && req;
        ed   = tb_run && !resp_stall && (mcnt[k] > 0) && (cyc >= mdue[k][mhead[k]]);
        er   = ed ? mdat[k][mhead[k]] : 32'd0;
        ew   = (eacc && wr) ? lane_mask(size, addr[1:0]) : 4'b0000;
        chk({p, " addr_ok"}, aok[k], ea);
        chk({p, " ram_en"}, ren[k], eacc);
        chk({p, " ram_wen"}, wen[k], ew);
        chk({p, " data_ok"}, dok[k], ed);
        chk({p, " rdata"}, rdat[k], er);
        if (eacc) begin
          chk({p, " ram_addr"}, raddr[k], {addr[31:2], 2'b00});
          chk({p, " ram_wdata"}, rwdat[k], wdata);
        end
        if (ed) begin
          mhead[k] = (mhead[k] + 1) % 8;
          mcnt[k]--;
        end
        if (eacc) begin
          slot = (mhead[k] + mcnt[k]) % 8;
          idx  = int'(addr[13:2]);
          mdue[k][slot] = cyc + 1 + ((k == 0) ? 0 : 3);
          mdat[k][slot] = wr ? 32'd0 : mmem[k][idx];
          if (wr)
            for (int b = 0; b < 4; b++)
              if (ew[b]) mmem[k][idx][8*b +: 8] = wdata[8*b +: 8];
          mcnt[k]++;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; wr = w; size = s; addr = a; wdata = d;
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  ew;
  } wvec_t;

  wvec_t wv [9];
  logic [5:0] pat_aok;
  logic [9:0] pat_dok;

  initial begin
    wv[0] = '{2'd0, 32'h2003, 32'hAB00_0000, 4'b1000};
    wv[1] = '{2'd1, 32'h2002, 32'hCDEF_0000, 4'b1100};
    wv[2] = '{2'd0, 32'h2000, 32'h0000_0011, 4'b0001};
    wv[3] = '{2'd0, 32'h2001, 32'h0000_2200, 4'b0010};
    wv[4] = '{2'd1, 32'h2000, 32'h0000_3344, 4'b0011};
    wv[5] = '{2'd2, 32'h2004, 32'h5566_7788, 4'b1111};
    wv[6] = '{2'd3, 32'h2009, 32'h99AA_BBCC, 4'b1111};
    wv[7] = '{2'd1, 32'h2003, 32'hEE00_0000, 4'b1000};
    wv[8] = '{2'd1, 32'h2001, 32'h00FF_FF00, 4'b0110};
    pat_aok = 6'b100011;
    pat_dok = 10'b1000110000;

    resetn = 1'b0; req_stall = 1'b0; resp_stall = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4096; i++) begin
        ram_st[k][i] = 32'hC0DE_0000 | i;
        mmem[k][i]   = 32'hC0DE_0000 | i;
      end
    for (int k = 0; k < 2; k++) begin
      ram_st[k][12'h400] = 32'hDEAD_BEEF;
      mmem[k][12'h400]   = 32'hDEAD_BEEF;
    end
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) tick();

    // DELAY=0 single read with bypassed data
    tick(); drive(1, 0, 2, 32'h1000, 0); smp();
    chk("d0 read accept", aok[0], 1);
    chk("d0 read ram_en", ren[0], 1);
    tick(); drive(0, 0, 0, 0, 0); smp();
    chk("d0 read data_ok", dok[0], 1);
    chk("d0 read rdata", rdat[0], 32'hDEAD_BEEF);
    tick(); smp();
    chk("d0 single data_ok", dok[0], 0);
    repeat (6) tick();

    // DELAY=3, OUTSTANDING=2: back-to-back reads hit the outstanding limit
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 6) drive(1, 0, 2, 32'h1000 + 4 * i, 0);
      else       drive(0, 0, 0, 0, 0);
      smp();
      if (i < 6) chk($sformatf("d3 b2b addr_ok[%0d]", i), aok[1], pat_aok[i]);
      chk($sformatf("d3 b2b data_ok[%0d]", i), dok[1], pat_dok[i]);
    end
    repeat (5) tick();

    // byte-enable table
    for (int v = 0; v < 9; v++) begin
      tick(); drive(1, 1, wv[v].sz, wv[v].a, wv[v].wd); smp();
      chk($sformatf("d0 wen vec%0d", v), wen[0], wv[v].ew);
      chk($sformatf("d3 wen vec%0d", v), wen[1], wv[v].ew);
      tick(); drive(0, 0, 0, 0, 0); smp();
      chk($sformatf("d0 wr data_ok vec%0d", v), dok[0], 1);
      chk($sformatf("d0 wr rdata vec%0d", v), rdat[0], 0);
      repeat (4) tick();
    end

    // resp_stall holds two ready responses while RAM output moves on
    tick(); resp_stall = 1'b1; drive(1, 0, 2, 32'h1000, 0); smp();
    tick(); drive(1, 0, 2, 32'h1004, 0); smp();
    chk("d0 stall data_ok0", dok[0], 0);
    tick(); drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      smp(); chk($sformatf("d0 stall data_ok%0d", i + 1), dok[0], 0);
      tick();
    end
    resp_stall = 1'b0; smp();
    chk("d0 release data_ok", dok[0], 1);
    chk("d0 release rdata", rdat[0], 32'hDEAD_BEEF);
    tick(); smp();
    chk("d0 second data_ok", dok[0], 1);
    chk("d0 second rdata", rdat[0], 32'hC0DE_0401);
    repeat (6) tick();

    // req_stall blocks acceptance
    tick(); req_stall = 1'b1; drive(1, 0, 2, 32'h1008, 0);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("d0 req_stall addr_ok", aok[0], 0);
      chk("d0 req_stall ram_en", ren[0], 0);
      chk("d3 req_stall addr_ok", aok[1], 0);
      tick();
    end
    req_stall = 1'b0; smp();
    chk("d0 unstall accept", aok[0], 1);
    chk("d0 unstall ram_en", ren[0], 1);
    tick(); drive(0, 0, 0, 0, 0);
    repeat (6) tick();

    // reset with two reads in flight
    tick(); drive(1, 0, 2, 32'h1000, 0); smp();
    tick(); drive(1, 0, 2, 32'h1004, 0); smp();
    tick(); drive(0, 0, 0, 0, 0); resetn = 1'b0; smp();
    chk("d3 in-reset addr_ok", aok[1], 0);
    chk("d3 in-reset data_ok", dok[1], 0);
    tick(); smp();
    tick(); resetn = 1'b1; smp();
    for (int i = 0; i < 9; i++) begin
      tick(); smp();
      if (i == 0) chk("d3 post-reset addr_ok", aok[1], 1);
      chk($sformatf("d3 post-reset data_ok%0d", i), dok[1], 0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), $urandom, $urandom);
      req_stall  = ($urandom_range(0, 7) == 0);
      resp_stall = ($urandom_range(0, 3) == 0);
    end
    tick(); drive(0, 0, 0, 0, 0); req_stall = 1'b0; resp_stall = 1'b0;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
